// File: rtl/heap_memory_if.sv
// heap_memory_if: allocate, store and read ports of the cons heap
interface heap_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_busy;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              alloc_req;
    logic [DATA_W-1:0] alloc_data;
    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_addr;
    logic              alloc_full;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              err;
    logic [ADDR_W:0]   free_ptr;
    modport master (
        output rd_req, rd_addr, alloc_req, alloc_data, wr_en, wr_addr, wr_data,
        input  rd_busy, rd_ready, rd_data, alloc_valid, alloc_addr, alloc_full, err, free_ptr
    );
    modport slave (
        input  rd_req, rd_addr, alloc_req, alloc_data, wr_en, wr_addr, wr_data,
        output rd_busy, rd_ready, rd_data, alloc_valid, alloc_addr, alloc_full, err, free_ptr
    );
endinterface

// File: rtl/heap_memory.sv
// heap_memory: bump-allocated cons heap with in-place store and a latency-configurable read port
module heap_memory #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input logic         clk,
    input logic         rst,
    heap_memory_if.slave bus
);
    localparam int              IW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] TOP = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAT = 4'(READ_LATENCY);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cap;
    logic [3:0]        cnt;
    logic              cap_zero, cap_oob;
    logic              alloc_ok, alloc_bad, wr_ok, wr_bad, rd_acc, rd_oob;

    always_comb begin
        alloc_ok  = bus.alloc_req && bus.free_ptr < TOP;
        alloc_bad = bus.alloc_req && !alloc_ok;
        wr_ok     = bus.wr_en && bus.wr_addr != '0 && {1'b0, bus.wr_addr} < bus.free_ptr;
        wr_bad    = bus.wr_en && !wr_ok;
        rd_acc    = bus.rd_req && cnt == '0;
        rd_oob    = {1'b0, bus.rd_addr} >= TOP;
    end

    assign bus.rd_busy    = cnt != '0;
    assign bus.alloc_full = bus.free_ptr == TOP;

    // Unreset storage with a registered read so the array maps onto block RAM;
    // wr_ok implies wr_addr < free_ptr, so the two write ports never collide.
    always_ff @(posedge clk) begin
        if (alloc_ok) mem[IW'(bus.free_ptr)] <= bus.alloc_data;
        if (wr_ok) mem[IW'(bus.wr_addr)] <= bus.wr_data;
        if (rd_acc) cap <= mem[IW'(bus.rd_addr)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            cap_zero        <= 1'b0;
            cap_oob         <= 1'b0;
            bus.free_ptr    <= (ADDR_W + 1)'(1);
            bus.rd_ready    <= 1'b0;
            bus.rd_data     <= '0;
            bus.alloc_valid <= 1'b0;
            bus.alloc_addr  <= '0;
            bus.err         <= 1'b0;
        end else begin
            bus.alloc_valid <= alloc_ok;
            bus.rd_ready    <= cnt == 4'd1;
            bus.err         <= alloc_bad | wr_bad | (cnt == 4'd1 && cap_oob);
            if (alloc_ok) begin
                bus.free_ptr   <= bus.free_ptr + (ADDR_W + 1)'(1);
                bus.alloc_addr <= bus.free_ptr[ADDR_W-1:0];
            end
            if (rd_acc) begin
                cnt      <= LAT;
                cap_zero <= bus.rd_addr == '0 || rd_oob;
                cap_oob  <= rd_oob;
            end else if (cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            // NIL and out-of-range reads return zero regardless of array contents
            if (cnt == 4'd1) bus.rd_data <= cap_zero ? '0 : cap;
        end
    end
endmodule

// File: tb/tb_heap_memory.sv
// tb_heap_memory: scoreboard bench driving a 4096-word latency-1 heap and an 8-word latency-3 heap
module tb_heap_memory;
    typedef struct {
        int          c;
        logic [15:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   k;
    exp_t e;
    exp_t rq0[$], rq1[$], aq0[$], aq1[$];
    int   eq0[$], eq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    heap_memory_if #(.DATA_W(16), .ADDR_W(12)) ia ();
    heap_memory_if #(.DATA_W(16), .ADDR_W(12)) ib ();

    heap_memory #(.DATA_W(16), .ADDR_W(12), .DEPTH(4096), .READ_LATENCY(1)) ua (.clk(clk), .rst(rst), .bus(ia));
    heap_memory #(.DATA_W(16), .ADDR_W(12), .DEPTH(8), .READ_LATENCY(3)) ub (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(string n, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, want);
        end
    endtask

    task automatic bad(string n, logic [31:0] v);
        checks++;
        errors++;
        $display("FAIL %s got %0h want none", n, v);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ia.alloc_valid) begin
                if (aq0.size() == 0) bad("a_alloc_extra", ia.alloc_addr);
                else begin e = aq0.pop_front(); chk("a_alloc_cyc", cyc, e.c); chk("a_alloc_addr", ia.alloc_addr, e.v); end
            end
            if (ia.rd_ready) begin
                if (rq0.size() == 0) bad("a_rd_extra", ia.rd_data);
                else begin e = rq0.pop_front(); chk("a_rd_cyc", cyc, e.c); chk("a_rd_data", ia.rd_data, e.v); end
            end
            if (ia.err) begin
                if (eq0.size() == 0) bad("a_err_extra", cyc);
                else chk("a_err_cyc", cyc, eq0.pop_front());
            end
            if (ib.alloc_valid) begin
                if (aq1.size() == 0) bad("b_alloc_extra", ib.alloc_addr);
                else begin e = aq1.pop_front(); chk("b_alloc_cyc", cyc, e.c); chk("b_alloc_addr", ib.alloc_addr, e.v); end
            end
            if (ib.rd_ready) begin
                if (rq1.size() == 0) bad("b_rd_extra", ib.rd_data);
                else begin e = rq1.pop_front(); chk("b_rd_cyc", cyc, e.c); chk("b_rd_data", ib.rd_data, e.v); end
            end
            if (ib.err) begin
                if (eq1.size() == 0) bad("b_err_extra", cyc);
                else chk("b_err_cyc", cyc, eq1.pop_front());
            end
        end
    end

    task automatic clear();
        ia.alloc_req = 1'b0; ia.wr_en = 1'b0; ia.rd_req = 1'b0;
        ib.alloc_req = 1'b0; ib.wr_en = 1'b0; ib.rd_req = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        clear();
    endtask

    task automatic push_err(int s, int c);
        if (s == 0) begin
            if (eq0.size() == 0 || eq0[$] != c) eq0.push_back(c);
        end else if (eq1.size() == 0 || eq1[$] != c) eq1.push_back(c);
    endtask

    task automatic alloc(int s, logic [15:0] d, int ea);
        if (s == 0) begin ia.alloc_req = 1'b1; ia.alloc_data = d; end
        else begin ib.alloc_req = 1'b1; ib.alloc_data = d; end
        if (ea == 0) push_err(s, cyc + 1);
        else if (s == 0) aq0.push_back(exp_t'{cyc + 1, 16'(ea)});
        else aq1.push_back(exp_t'{cyc + 1, 16'(ea)});
    endtask

    task automatic store(int s, logic [11:0] a, logic [15:0] d, bit rej);
        if (s == 0) begin ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; end
        else begin ib.wr_en = 1'b1; ib.wr_addr = a; ib.wr_data = d; end
        if (rej) push_err(s, cyc + 1);
    endtask

    task automatic read(int s, logic [11:0] a, logic [15:0] want, bit oob);
        int lat;
        lat = s == 0 ? 1 : 3;
        if (s == 0) begin ia.rd_req = 1'b1; ia.rd_addr = a; rq0.push_back(exp_t'{cyc + 1 + lat, want}); end
        else begin ib.rd_req = 1'b1; ib.rd_addr = a; rq1.push_back(exp_t'{cyc + 1 + lat, want}); end
        if (oob) push_err(s, cyc + 1 + lat);
    endtask

    initial begin
        ia.rd_addr = '0; ia.alloc_data = '0; ia.wr_addr = '0; ia.wr_data = '0;
        ib.rd_addr = '0; ib.alloc_data = '0; ib.wr_addr = '0; ib.wr_data = '0;
        clear();
        repeat (2) @(negedge clk);
        chk("rst_a_free_ptr", ia.free_ptr, 1);
        chk("rst_b_free_ptr", ib.free_ptr, 1);
        chk("rst_a_flags", {ia.rd_busy, ia.rd_ready, ia.alloc_valid, ia.err, ia.alloc_full}, 0);
        chk("rst_a_data", {ia.rd_data, ia.alloc_addr}, 0);
        chk("rst_b_flags", {ib.rd_busy, ib.rd_ready, ib.alloc_valid, ib.err, ib.alloc_full}, 0);
        chk("rst_b_data", {ib.rd_data, ib.alloc_addr}, 0);
        rst = 1'b0;
        next();
        // back-to-back allocs then reads at latency 1
        alloc(0, 16'hBEEF, 1); next();
        alloc(0, 16'hDEAD, 2); next();
        alloc(0, 16'hDEF0, 3); next();
        chk("a_free_ptr_4", ia.free_ptr, 4);
        chk("a_not_full", ia.alloc_full, 0);
        read(0, 1, 16'hBEEF, 0); next(); next();
        read(0, 2, 16'hDEAD, 0); next(); next();
        read(0, 3, 16'hDEF0, 0); next(); next();
        // rejected stores to NIL and to free_ptr; NIL reads as zero without error
        store(0, 0, 16'h1111, 1); next();
        store(0, 4, 16'h2222, 1); next();
        read(0, 0, 16'h0000, 0); next(); next();
        read(0, 1, 16'hBEEF, 0); next(); next();
        // store, alloc and read on one edge; the read sees the pre-store word
        store(0, 2, 16'h5A5A, 0); read(0, 2, 16'hDEAD, 0); alloc(0, 16'hAAAA, 4); next(); next();
        read(0, 2, 16'h5A5A, 0); next(); next();
        read(0, 4, 16'hAAAA, 0); next(); next();
        // fill the 8-word heap; a store to the cell being allocated is rejected
        for (int i = 1; i <= 7; i++) begin
            alloc(1, 16'h1100 + 16'(i), i);
            if (i == 4) store(1, 4, 16'h7777, 1);
            next();
        end
        chk("b_full", ib.alloc_full, 1);
        chk("b_free_ptr_8", ib.free_ptr, 8);
        alloc(1, 16'h9999, 0); next();
        chk("b_free_ptr_hold", ib.free_ptr, 8);
        chk("b_full_hold", ib.alloc_full, 1);
        store(1, 5, 16'h1234, 0); next();
        read(1, 5, 16'h1234, 0); repeat (4) next();
        // rd_req held high: second request waits until after rd_ready
        k = cyc;
        read(1, 2, 16'h1102, 0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) begin ib.rd_addr = 3; rq1.push_back(exp_t'{k + 8, 16'h1103}); end
            chk("b_busy", ib.rd_busy, j != 4);
        end
        ib.rd_req = 1'b0;
        repeat (4) next();
        read(1, 9, 16'h0000, 1); repeat (4) next();
        read(1, 0, 16'h0000, 0); repeat (4) next();
        read(1, 4, 16'h1104, 0); repeat (4) next();
        // reset mid-read on b and during back-to-back allocs on a
        alloc(0, 16'h0A05, 5); ib.rd_req = 1'b1; ib.rd_addr = 1; next();
        alloc(0, 16'h0A06, 6); next();
        ia.alloc_req = 1'b1; ia.alloc_data = 16'h0A07;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_a", {ia.alloc_valid, ia.alloc_addr, ia.free_ptr}, 1);
        chk("rst_mid_b", {ib.rd_busy, ib.rd_ready, ib.free_ptr, ib.alloc_full}, 2);
        next();
        rst = 1'b0;
        alloc(0, 16'h0B01, 1); alloc(1, 16'h2222, 1); read(1, 1, 16'h1101, 0); next();
        repeat (3) next();
        read(1, 1, 16'h2222, 0); repeat (4) next();
        read(0, 1, 16'h0B01, 0); next(); next();
        repeat (3) next();
        chk("a_rd_left", rq0.size(), 0);
        chk("a_alloc_left", aq0.size(), 0);
        chk("a_err_left", eq0.size(), 0);
        chk("b_rd_left", rq1.size(), 0);
        chk("b_alloc_left", aq1.size(), 0);
        chk("b_err_left", eq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
